// File: rtl/jtag_host_shifter.sv
// -----------------------------------------------------------------------------
// jtag_host_shifter
//
// Host-side JTAG scan engine. Drives a target TAP through a complete IR or DR
// scan (or a Test-Logic-Reset sequence) and captures the bits returned on TDO.
// All flops run on the rising edge of TCK; TMS/TDI are registered, so the
// target samples each value on the following rising TCK.
//
// Ports
//   TCK      in   scan clock
//   TRST     in   asynchronous active-low reset
//   start    in   request a scan (accepted only in IDLE)
//   is_ir    in   1 = IR scan, 0 = DR scan (sampled with start)
//   len      in   scan length in bits, 0 -> 1, >MAX_LEN -> MAX_LEN
//   tx_data  in   bits shifted out on TDI, LSB first (sampled with start)
//   tlr_req  in   request a Test-Logic-Reset sequence (wins over start)
//   TDO      in   serial data from the target TAP
//   TMS      out  mode select to the target TAP
//   TDI      out  serial data to the target TAP
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse in the first IDLE cycle after a scan/TLR
//   rx_data  out  bits captured from TDO, LSB first; upper bits stay 0
// -----------------------------------------------------------------------------
module jtag_host_shifter #(
  parameter int MAX_LEN = 32
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               start,
  input  logic               is_ir,
  input  logic [5:0]         len,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               tlr_req,
  input  logic               TDO,
  output logic               TMS,
  output logic               TDI,
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] rx_data
);

  // Shift counter wide enough to hold MAX_LEN itself, so it never wraps.
  localparam int CW = $clog2(MAX_LEN) + 1;

  // Index of the last TLR_SEQ cycle (TMS=0); cycles 0..4 drive TMS=1.
  localparam logic [2:0] TLR_LAST = 3'd5;

  typedef enum logic [2:0] {
    TLR_SEQ = 3'd0,
    IDLE    = 3'd1,
    SEL_DR  = 3'd2,
    SEL_IR  = 3'd3,
    CAPTURE = 3'd4,
    SHIFT   = 3'd5,
    EXIT1   = 3'd6,
    UPDATE  = 3'd7
  } state_e;

  state_e             state_q,   state_d;
  logic [2:0]         tlr_cnt_q, tlr_cnt_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [CW-1:0]      len_q,     len_d;
  logic               ir_q,      ir_d;
  logic [MAX_LEN-1:0] tx_q,      tx_d;
  logic [MAX_LEN-1:0] rx_q,      rx_d;
  logic [MAX_LEN-1:0] mask_q,    mask_d;
  logic               tms_q,     tms_d;
  logic               tdi_q,     tdi_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  // Effective scan length: zero means one bit, oversize saturates.
  function automatic logic [CW-1:0] clamp_len(input logic [5:0] l);
    if (l == 6'd0) begin
      return CW'(1'b1);
    end else if (int'(l) > MAX_LEN) begin
      return CW'(MAX_LEN);
    end else begin
      return CW'(l);
    end
  endfunction

  // TMS value presented while in a given state/count.
  function automatic logic tms_of(input state_e s, input logic [2:0] tc,
                                  input logic [CW-1:0] c, input logic [CW-1:0] l);
    case (s)
      TLR_SEQ:               return (tc != TLR_LAST);
      SEL_DR, SEL_IR, EXIT1: return 1'b1;
      SHIFT:                 return (c == l - CW'(1'b1));
      default:               return 1'b0;
    endcase
  endfunction

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d   = state_q;
    tlr_cnt_d = tlr_cnt_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ir_d      = ir_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    case (state_q)
      TLR_SEQ: begin
        if (tlr_cnt_q == TLR_LAST) begin
          state_d   = IDLE;
          tlr_cnt_d = 3'd0;
          done_d    = 1'b1;
        end else begin
          tlr_cnt_d = tlr_cnt_q + 3'd1;
        end
      end
      IDLE: begin
        if (tlr_req) begin
          state_d   = TLR_SEQ;
          tlr_cnt_d = 3'd0;
        end else if (start) begin
          state_d = SEL_DR;
          ir_d    = is_ir;
          len_d   = clamp_len(len);
          tx_d    = tx_data;
          rx_d    = {MAX_LEN{1'b0}};
          // One-hot write pointer into rx: bit i is filled on shift cycle i.
          mask_d  = MAX_LEN'(1'b1);
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SEL_DR: begin
        if (ir_q) begin
          state_d = SEL_IR;
        end else begin
          state_d = CAPTURE;
          cnt_d   = {CW{1'b0}};
        end
      end
      SEL_IR: begin
        state_d = CAPTURE;
        cnt_d   = {CW{1'b0}};
      end
      CAPTURE: begin
        // Two TMS=0 cycles: the target passes Capture and enters Shift.
        if (cnt_q == {CW{1'b0}}) begin
          cnt_d = CW'(1'b1);
        end else begin
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rx_d   = rx_q | (TDO ? mask_q : {MAX_LEN{1'b0}});
        mask_d = mask_q << 1'b1;
        tx_d   = tx_q >> 1'b1;
        if (cnt_q == len_q - CW'(1'b1)) begin
          state_d = EXIT1;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      EXIT1: begin
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d   = TLR_SEQ;
        tlr_cnt_d = 3'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins come straight from flops.
  always_comb begin
    tms_d  = tms_of(state_d, tlr_cnt_d, cnt_d, len_q);
    // tx_d[0] is the bit for the shift cycle being entered.
    tdi_d  = (state_d == SHIFT) ? tx_d[0] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; TRST aborts everything into TLR_SEQ.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q   <= TLR_SEQ;
      tlr_cnt_q <= 3'd0;
      cnt_q     <= {CW{1'b0}};
      len_q     <= {CW{1'b0}};
      ir_q      <= 1'b0;
      tx_q      <= {MAX_LEN{1'b0}};
      rx_q      <= {MAX_LEN{1'b0}};
      mask_q    <= {MAX_LEN{1'b0}};
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tlr_cnt_q <= tlr_cnt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ir_q      <= ir_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      mask_q    <= mask_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TMS     = tms_q;
  assign TDI     = tdi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_shifter
//
// Scoreboard bench for jtag_host_shifter. Stimulus tasks plan the expected
// pin activity per cycle (TMS/TDI/busy) from the scan-sequence rules and push
// the expected completion (done cycle, rx_data) into a queue; a monitor on the
// falling edge compares pins every cycle and pops the queue on each done.
// -----------------------------------------------------------------------------
module tb_jtag_host_shifter;

  localparam int NCYC = 8192;

  logic        TCK = 1'b0;
  logic        TRST = 1'b1;
  logic        start = 1'b0;
  logic        is_ir = 1'b0;
  logic [5:0]  len = 6'd0;
  logic [31:0] tx_data = 32'd0;
  logic        tlr_req = 1'b0;
  logic        TDO;
  logic        TMS, TDI, busy, done;
  logic [31:0] rx_data;

  logic tdo_src = 1'b0;
  logic loop_mode = 1'b0;
  assign TDO = loop_mode ? TDI : tdo_src;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int last_d = 0;
  int last_done_cyc = -1;
  logic [31:0] last_rx = 32'd0;

  bit tdo_bits [NCYC];
  int exp_tms  [NCYC];
  int exp_tdi  [NCYC];
  int exp_busy [NCYC];

  typedef struct {
    int          cyc;
    logic [31:0] rx;
  } exp_t;
  exp_t sb_q[$];

  jtag_host_shifter #(.MAX_LEN(32)) dut (
    .TCK     (TCK),
    .TRST    (TRST),
    .start   (start),
    .is_ir   (is_ir),
    .len     (len),
    .tx_data (tx_data),
    .tlr_req (tlr_req),
    .TDO     (TDO),
    .TMS     (TMS),
    .TDI     (TDI),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  always #5 TCK = ~TCK;

  // Cycle n is the interval after the n-th rising edge.
  always @(posedge TCK) cyc <= cyc + 1;

  // Target TDO: a prepared random bit per cycle, stable before the next edge.
  always @(negedge TCK) tdo_src <= (cyc < NCYC) ? tdo_bits[cyc] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: per-cycle pin checks plus scoreboard pop on done.
  always @(negedge TCK) begin
    if (cyc < NCYC) begin
      if (exp_tms[cyc]  >= 0) chk("tms",  32'(TMS),  exp_tms[cyc]);
      if (exp_tdi[cyc]  >= 0) chk("tdi",  32'(TDI),  exp_tdi[cyc]);
      if (exp_busy[cyc] >= 0) chk("busy", 32'(busy), exp_busy[cyc]);
    end
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done @cycle %0d: got done=1, expected done=0", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("rx_data", rx_data, e.rx);
        last_done_cyc = cyc;
      end
    end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_done @cycle %0d: got done=0, expected done=1", cyc);
      sb_q.delete(0);
    end
  end

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_exp(input int c, input int t, input int d, input int b);
    if (c >= 0 && c < NCYC) begin
      exp_tms[c]  = t;
      exp_tdi[c]  = d;
      exp_busy[c] = b;
    end
  endtask

  task automatic fill_idle(input int a);
    for (int c = last_d; c < a; c++) set_exp(c, 0, 0, 0);
  endtask

  // TLR sequence starting in cycle a: TMS 1,1,1,1,1,0 then done in IDLE.
  task automatic plan_tlr(input int a);
    for (int j = 0; j < 6; j++) set_exp(a + j, (j < 5) ? 1 : 0, 0, 1);
    set_exp(a + 6, 0, 0, 0);
    sb_q.push_back('{a + 6, last_rx});
    last_d = a + 7;
  endtask

  // Issue one scan; abort_bit >= 0 pulls TRST low in that shift cycle.
  task automatic do_scan(input bit ir, input logic [5:0] l, input logic [31:0] tx,
                         input bit loop, input bit poke, input int abort_bit,
                         output int d_out);
    int a, eff, off, d, c0;
    logic [31:0] expv;
    loop_mode = loop;
    a   = cyc + 1;
    eff = (l == 6'd0) ? 1 : ((int'(l) > 32) ? 32 : int'(l));
    off = ir ? 4 : 3;
    d   = a + off + eff + 2;
    expv = 32'd0;
    for (int i = 0; i < eff; i++) expv[i] = loop ? tx[i] : tdo_bits[a + off + i];
    fill_idle(a);
    set_exp(a, 1, 0, 1);
    if (ir) set_exp(a + 1, 1, 0, 1);
    set_exp(a + off - 2, 0, 0, 1);
    set_exp(a + off - 1, 0, 0, 1);
    for (int i = 0; i < eff; i++) set_exp(a + off + i, (i == eff - 1) ? 1 : 0, int'(tx[i]), 1);
    set_exp(a + off + eff, 1, 0, 1);
    set_exp(a + off + eff + 1, 0, 0, 1);
    set_exp(d, 0, 0, 0);
    sb_q.push_back('{d, expv});
    last_rx = expv;
    last_d  = d + 1;
    is_ir = ir; len = l; tx_data = tx; start = 1'b1;
    step();
    start = 1'b0;
    is_ir = 1'($urandom); len = 6'($urandom); tx_data = $urandom;
    if (poke) begin
      step();
      step();
      start = 1'b1; tlr_req = 1'b1; tx_data = $urandom;
      step();
      start = 1'b0; tlr_req = 1'b0;
    end
    if (abort_bit >= 0) begin
      wait_until(a + off + abort_bit);
      c0 = cyc;
      TRST = 1'b0;
      sb_q.delete();
      for (int c = c0; c <= d; c++) set_exp(c, -1, -1, -1);
      for (int c = c0; c < c0 + 3; c++) set_exp(c, 1, 0, 1);
      #1;
      chk("abort_tms",  32'(TMS),  32'd1);
      chk("abort_busy", 32'(busy), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rx",   rx_data,   32'd0);
      step(); step(); step();
      TRST = 1'b1;
      last_rx = 32'd0;
      last_d  = cyc;
      d = cyc + 6;
      plan_tlr(cyc);
    end
    wait_until(d);
    d_out = d;
  endtask

  task automatic do_tlr(input bit with_start);
    int a;
    a = cyc + 1;
    fill_idle(a);
    plan_tlr(a);
    tlr_req = 1'b1; start = with_start;
    is_ir = 1'($urandom); len = 6'($urandom); tx_data = $urandom;
    step();
    tlr_req = 1'b0; start = 1'b0;
    wait_until(a + 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, a, d, op;
    logic [31:0] tx;
    logic [4:0]  pat;
    for (int i = 0; i < NCYC; i++) begin
      tdo_bits[i] = 1'($urandom);
      exp_tms[i] = -1; exp_tdi[i] = -1; exp_busy[i] = -1;
    end
    #2 TRST = 1'b0;
    step(); step(); step();
    chk("rst_tms",  32'(TMS),  32'd1);
    chk("rst_tdi",  32'(TDI),  32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx",   rx_data,   32'd0);

    // Reset release runs the TLR sequence on its own.
    k = cyc;
    TRST = 1'b1;
    last_rx = 32'd0;
    last_d = k;
    plan_tlr(k);
    wait_until(k + 6);

    // IR scan, len 5, target returns 1,0,1,0,1.
    a = cyc + 1;
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) tdo_bits[a + 4 + i] = pat[i];
    do_scan(1'b1, 6'd5, 32'h0000_0002, 1'b0, 1'b0, -1, d);
    @(negedge TCK); #1;
    chk("ir_rx", rx_data, 32'h0000_0015);
    chk("ir_latency", 32'(last_done_cyc - (a - 1)), 32'd12);
    step();

    // DR scan, len 32, TDO looped back.
    a = cyc + 1;
    do_scan(1'b0, 6'd32, 32'hDEAD_BEEF, 1'b1, 1'b0, -1, d);
    @(negedge TCK); #1;
    chk("dr_rx", rx_data, 32'hDEAD_BEEF);
    chk("dr_latency", 32'(last_done_cyc - (a - 1)), 32'd38);
    step();

    // Boundary lengths.
    do_scan(1'b0, 6'd1, $urandom, 1'b0, 1'b0, -1, d);
    tx = $urandom;
    do_scan(1'b0, 6'd0, tx, 1'b1, 1'b0, -1, d);
    chk("len0_rx", rx_data, tx & 32'h1);
    tx = $urandom;
    do_scan(1'b1, 6'd40, tx, 1'b1, 1'b0, -1, d);
    chk("len40_rx", rx_data, tx);

    // Contention: requests while busy, then tlr_req with start in IDLE.
    do_scan(1'b0, 6'd8, $urandom, 1'b0, 1'b1, -1, d);
    do_tlr(1'b1);
    chk("tlr_keeps_rx", rx_data, last_rx);

    // Reset during shift cycle 3.
    do_scan(1'b0, 6'd10, $urandom, 1'b0, 1'b0, 3, d);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_tlr(1'($urandom));
      end else if (op == 1) begin
        do_scan(1'($urandom), 6'($urandom_range(4, 45)), $urandom, 1'b0, 1'b0,
                $urandom_range(0, 3), d);
      end else begin
        do_scan(1'($urandom), 6'($urandom_range(0, 45)), $urandom, 1'($urandom),
                1'($urandom), -1, d);
      end
    end

    step(); step(); step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
